// File: rtl/spi_reg_slave.sv
// spi_reg_slave: SPI slave register bridge (oversampled SPI pins, single clk).
// Address 0 returns CHIP_ID, addresses 1..N_RO read ro_in, and addresses
// N_RO+1..N_RO+N_RW are read/write bytes driven onto rw_out.
// Optional feature macro: SPI_BURST_AUTOINC_EN (burst data bytes with
// address auto-increment). Undefined: alternating command/data pairs.
//
// state   | meaning
// IDLE    | ss_n high, sck ignored
// CMD     | receiving command byte (bit7 = read, bits[6:0] = address)
// DATA    | receiving data byte / shifting read data out on miso
`timescale 1ns/1ps

module spi_reg_slave #(
    parameter logic [7:0] CHIP_ID     = 8'h07,
    parameter int         N_RO        = 2,
    parameter int         N_RW        = 2,
    parameter int         SPI_MODE    = 0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [8*N_RO-1:0] ro_in,
    output logic [8*N_RW-1:0] rw_out,
    output logic              wr_stb,
    output logic [6:0]        wr_addr,
    output logic              busy
);

    localparam bit CPOL = ((SPI_MODE >> 1) & 1) == 1;
    localparam bit CPHA = (SPI_MODE & 1) == 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_prev_q, ss_prev_q;
    logic                   sck_s, ss_s, mosi_s;
    logic                   sck_rise, sck_fall, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge;
    logic                   ss_fall, ss_rise, in_frame;
    logic                   do_sample, do_shift, byte_done;

    logic [1:0]        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_q, rx_d, rx_next;
    logic [7:0]        tx_q, tx_d;
    logic              cmd_rd_q, cmd_rd_d;
    logic [6:0]        addr_q, addr_d;
    logic [8*N_RW-1:0] rw_q, rw_d;
    logic              wr_stb_q, wr_stb_d;
    logic [6:0]        wr_addr_q, wr_addr_d;

    logic [6:0]        rd_addr;
    logic [7:0]        rd_data;
    logic              wr_hit;

    // Synchronise the SPI pins and keep the previous synchronised level for edge detection.
    // ss_n resets to its idle (high) level so leaving reset never looks like a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
            ss_prev_q   <= ss_s;
        end
    end

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;
    assign lead_edge   = CPOL ? sck_fall : sck_rise;
    assign trail_edge  = CPOL ? sck_rise : sck_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;

    assign ss_fall  = ~ss_s & ss_prev_q;
    assign ss_rise  = ss_s & ~ss_prev_q;
    // state_q still shows the frame in the cycle ss_n rises, so a sample landing
    // in that same cycle completes its byte.
    assign in_frame = (state_q != ST_IDLE);

    // The shift edge at bit count 0 is skipped: it is either the trailing edge
    // right after a byte-boundary load (CPHA=0) or the first leading edge of a
    // byte whose MSB is already on miso (CPHA=1).
    assign do_sample = in_frame & sample_edge;
    assign do_shift  = in_frame & shift_edge & (bit_cnt_q != 3'd0);
    assign rx_next   = {rx_q[6:0], mosi_s};
    assign byte_done = do_sample & (bit_cnt_q == 3'd7);

`ifdef SPI_BURST_AUTOINC_EN
    logic [6:0] addr_inc;
    assign addr_inc = addr_q + 7'd1;
    assign rd_addr  = (state_q == ST_DATA) ? addr_inc : rx_next[6:0];
`else
    assign rd_addr  = rx_next[6:0];
`endif

    // Read map and write-address decode.
    always_comb begin
        rd_data = 8'h00;
        wr_hit  = 1'b0;
        if (rd_addr == 7'd0) begin
            rd_data = CHIP_ID;
        end
        for (int k = 0; k < N_RO; k++) begin
            if (rd_addr == 7'(k + 1)) begin
                rd_data = ro_in[8*k +: 8];
            end
        end
        for (int k = 0; k < N_RW; k++) begin
            if (rd_addr == 7'(N_RO + 1 + k)) begin
                rd_data = rw_q[8*k +: 8];
            end
            if (addr_q == 7'(N_RO + 1 + k)) begin
                wr_hit = 1'b1;
            end
        end
    end

    // Frame sequencing, shift registers and register-write commit.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        cmd_rd_d  = cmd_rd_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;

        if (do_sample) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
        end else if (do_shift) begin
            tx_d = {tx_q[6:0], 1'b0};
        end

        if (byte_done) begin
            if (state_q == ST_CMD) begin
                cmd_rd_d = rx_next[7];
                addr_d   = rx_next[6:0];
                tx_d     = rx_next[7] ? rd_data : 8'h00;
                state_d  = ST_DATA;
            end else begin
                if (!cmd_rd_q && wr_hit) begin
                    for (int k = 0; k < N_RW; k++) begin
                        if (addr_q == 7'(N_RO + 1 + k)) begin
                            rw_d[8*k +: 8] = rx_next;
                        end
                    end
                    wr_stb_d  = 1'b1;
                    wr_addr_d = addr_q;
                end
`ifdef SPI_BURST_AUTOINC_EN
                addr_d = addr_inc;
                tx_d   = cmd_rd_q ? rd_data : 8'h00;
`else
                tx_d    = 8'h00;
                state_d = ST_CMD;
`endif
            end
        end

        if (ss_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            tx_d      = 8'h00;
        end
        if (ss_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            rx_d      = 8'h00;
            tx_d      = 8'h00;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            cmd_rd_q  <= 1'b0;
            addr_q    <= 7'd0;
            rw_q      <= '0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= 7'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            cmd_rd_q  <= cmd_rd_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    assign miso    = tx_q[7];
    assign miso_oe = in_frame;
    assign busy    = in_frame;
    assign rw_out  = rw_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Testbench for spi_reg_slave: a mode-0 and a mode-3 instance driven by a
// behavioural SPI master, with table-driven frames plus corner sequences.
`timescale 1ns/1ps

module tb_spi_reg_slave;

    localparam int HALF = 80;   // half SCK period in ns (clk period 10 ns)

    logic        clk, rst;
    logic        sck0, ss0, sck3, ss3, mosi;
    logic [15:0] ro_in;
    logic        miso0, oe0, stb0, busy0;
    logic        miso3, oe3, stb3, busy3;
    logic [15:0] rw0, rw3;
    logic [6:0]  wa0, wa3;

    int n_tests = 0;
    int n_fail  = 0;
    int vec_id  = 0;
    bit sel     = 0;           // 0: mode-0 DUT, 1: mode-3 DUT

    int         cnt0 = 0, cnt3 = 0;
    logic [6:0] log0 [0:255];
    logic [6:0] log3 [0:255];

    spi_reg_slave #(.SPI_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .sck(sck0), .ss_n(ss0), .mosi(mosi),
        .miso(miso0), .miso_oe(oe0), .ro_in(ro_in), .rw_out(rw0),
        .wr_stb(stb0), .wr_addr(wa0), .busy(busy0));

    spi_reg_slave #(.SPI_MODE(3)) dut3 (
        .clk(clk), .rst(rst), .sck(sck3), .ss_n(ss3), .mosi(mosi),
        .miso(miso3), .miso_oe(oe3), .ro_in(ro_in), .rw_out(rw3),
        .wr_stb(stb3), .wr_addr(wa3), .busy(busy3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count and log every wr_stb cycle (a stuck strobe inflates the count).
    always @(negedge clk) begin
        if (stb0 === 1'b1) begin
            log0[cnt0[7:0]] <= wa0;
            cnt0 <= cnt0 + 1;
        end
        if (stb3 === 1'b1) begin
            log3[cnt3[7:0]] <= wa3;
            cnt3 <= cnt3 + 1;
        end
    end

    typedef struct {
        logic [15:0] ro;
        int          n;
        logic [31:0] tx;       // byte j at [8j+7:8j]
        logic [3:0]  mask;     // which received bytes to check
        logic [31:0] exp_rx;
        logic [15:0] exp_rw;
        int          exp_stb;
        logic [6:0]  exp_a0;
        logic [6:0]  exp_a1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [15:0] ro, input int n,
                                input logic [7:0] b0, b1, b2, b3, input logic [3:0] mask,
                                input logic [7:0] e0, e1, e2, e3, input logic [15:0] erw,
                                input int estb, input logic [6:0] a0, a1);
        vec_t v;
        v.ro = ro; v.n = n; v.tx = {b3, b2, b1, b0}; v.mask = mask;
        v.exp_rx = {e3, e2, e1, e0}; v.exp_rw = erw; v.exp_stb = estb;
        v.exp_a0 = a0; v.exp_a1 = a1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (mode %0d, item %0d): got %h, expected %h",
                     name, sel ? 3 : 0, vec_id, act, exp);
        end
    endtask

    task automatic set_sck(input logic v);
        if (sel) sck3 = v; else sck0 = v;
    endtask
    task automatic set_ss(input logic v);
        if (sel) ss3 = v; else ss0 = v;
    endtask
    function automatic logic get_miso();
        return sel ? miso3 : miso0;
    endfunction
    function automatic logic [15:0] cur_rw();
        return sel ? rw3 : rw0;
    endfunction
    function automatic int cur_cnt();
        return sel ? cnt3 : cnt0;
    endfunction
    function automatic logic [6:0] cur_log(input int i);
        return sel ? log3[i[7:0]] : log0[i[7:0]];
    endfunction
    function automatic logic cur_busy();
        return sel ? busy3 : busy0;
    endfunction
    function automatic logic cur_oe();
        return sel ? oe3 : oe0;
    endfunction
    function automatic logic [6:0] cur_wa();
        return sel ? wa3 : wa0;
    endfunction

    // Shift nbits (MSB first) of tx; optionally raise ss_n together with the last sample edge.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit ss_at_last,
                        output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            if (!sel) begin
                mosi = tx[i];
                #(HALF);
                set_sck(1'b1);
                rx[i] = get_miso();
                if (ss_at_last && i == 0) set_ss(1'b1);
                #(HALF);
                set_sck(1'b0);
            end else begin
                set_sck(1'b0);
                mosi = tx[i];
                #(HALF);
                set_sck(1'b1);
                rx[i] = get_miso();
                if (ss_at_last && i == 0) set_ss(1'b1);
                #(HALF);
            end
        end
    endtask

    task automatic frame(input int n, input logic [31:0] tx, output logic [31:0] rx);
        logic [7:0] r;
        rx = '0;
        set_ss(1'b0);
        #(HALF);
        for (int j = 0; j < n; j++) begin
            xfer(tx[8*j +: 8], 8, 1'b0, r);
            rx[8*j +: 8] = r;
        end
        #(HALF);
        set_ss(1'b1);
        set_sck(sel);
        #(2*HALF);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] rx;
        int          c0;
        ro_in = v.ro;
        c0 = cur_cnt();
        frame(v.n, v.tx, rx);
        for (int j = 0; j < 4; j++)
            if (v.mask[j]) chk($sformatf("rx_byte%0d", j), 32'(rx[8*j +: 8]), 32'(v.exp_rx[8*j +: 8]));
        chk("rw_out", 32'(cur_rw()), 32'(v.exp_rw));
        chk("wr_stb_count", 32'(cur_cnt() - c0), 32'(v.exp_stb));
        if (v.exp_stb >= 1) chk("wr_addr_first", 32'(cur_log(c0)), 32'(v.exp_a0));
        if (v.exp_stb >= 2) chk("wr_addr_second", 32'(cur_log(c0 + 1)), 32'(v.exp_a1));
        if (v.exp_stb == 1) chk("wr_addr_port", 32'(cur_wa()), 32'(v.exp_a0));
        if (v.exp_stb == 2) chk("wr_addr_port", 32'(cur_wa()), 32'(v.exp_a1));
    endtask

    task automatic run_mode(input logic [15:0] rw_start);
        logic [7:0]  r;
        logic [31:0] rx;
        logic [15:0] rw_exp;
        int          c0;
        for (int i = 0; i < vecs.size(); i++) begin
            vec_id = i;
            run_vec(vecs[i]);
        end
        // ss_n rises in the same clk as the 8th sample: the write still commits.
        vec_id = 100;
        rw_exp = {rw_start[15:8], 8'h5A};
        c0 = cur_cnt();
        set_ss(1'b0);
        #(HALF);
        xfer(8'h03, 8, 1'b0, r);
        xfer(8'h5A, 8, 1'b1, r);
        #(HALF);
        set_sck(sel);
        #(2*HALF);
        chk("simul_rw_out", 32'(cur_rw()), 32'(rw_exp));
        chk("simul_wr_stb_count", 32'(cur_cnt() - c0), 32'd1);
        chk("simul_wr_addr", 32'(cur_wa()), 32'd3);
        // Abort after half a data byte: no write.
        vec_id = 101;
        c0 = cur_cnt();
        set_ss(1'b0);
        #(HALF);
        chk("busy_in_frame", 32'(cur_busy()), 32'd1);
        chk("miso_oe_in_frame", 32'(cur_oe()), 32'd1);
        xfer(8'h03, 8, 1'b0, r);
        xfer(8'h12, 4, 1'b0, r);
        #(HALF);
        set_ss(1'b1);
        set_sck(sel);
        #(2*HALF);
        chk("abort_rw_out", 32'(cur_rw()), 32'(rw_exp));
        chk("abort_wr_stb_count", 32'(cur_cnt() - c0), 32'd0);
        chk("abort_busy", 32'(cur_busy()), 32'd0);
        // Next frame starts cleanly after the abort.
        vec_id = 102;
        frame(2, {16'h0000, 8'h00, 8'h83}, rx);
        chk("post_abort_read3", 32'(rx[15:8]), 32'h5A);
        frame(2, {16'h0000, 8'h00, 8'h84}, rx);
        chk("post_abort_read4", 32'(rx[15:8]), 32'(rw_exp[15:8]));
    endtask

    initial begin
        logic [31:0] rx;
        logic [7:0]  r;
        logic [15:0] rw_final;
        rst = 1'b1; sck0 = 1'b0; sck3 = 1'b1; ss0 = 1'b1; ss3 = 1'b1; mosi = 1'b0;
        ro_in = 16'h0000;

`ifdef SPI_BURST_AUTOINC_EN
        vecs.push_back(mk(16'h0000, 3, 8'h03, 8'h11, 8'h22, 8'h00, 4'b0111,
                          8'h00, 8'h00, 8'h00, 8'h00, 16'h2211, 2, 7'd3, 7'd4));
        vecs.push_back(mk(16'h0000, 3, 8'h83, 8'h00, 8'h00, 8'h00, 4'b0111,
                          8'h00, 8'h11, 8'h22, 8'h00, 16'h2211, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'h00FF, 4, 8'h80, 8'h00, 8'h00, 8'h00, 4'b1111,
                          8'h00, 8'h07, 8'hFF, 8'h00, 16'h2211, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'h0000, 3, 8'hFF, 8'h00, 8'h00, 8'h00, 4'b0111,
                          8'h00, 8'h00, 8'h07, 8'h00, 16'h2211, 0, 7'd0, 7'd0));
        rw_final = 16'h2211;
`else
        vecs.push_back(mk(16'h0000, 4, 8'h80, 8'h00, 8'h80, 8'h00, 4'b1111,
                          8'h00, 8'h07, 8'h00, 8'h07, 16'h0000, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'h00FF, 4, 8'h81, 8'h81, 8'h82, 8'h82, 4'b1111,
                          8'h00, 8'hFF, 8'h00, 8'h00, 16'h0000, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'h00FF, 4, 8'h03, 8'hFF, 8'h04, 8'hAA, 4'b1111,
                          8'h00, 8'h00, 8'h00, 8'h00, 16'hAAFF, 2, 7'd3, 7'd4));
        vecs.push_back(mk(16'h00FF, 4, 8'h83, 8'h00, 8'h84, 8'h00, 4'b1111,
                          8'h00, 8'hFF, 8'h00, 8'hAA, 16'hAAFF, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'h00FF, 4, 8'h00, 8'h55, 8'h7F, 8'h55, 4'b1111,
                          8'h00, 8'h00, 8'h00, 8'h00, 16'hAAFF, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'h00FF, 4, 8'h01, 8'h55, 8'hFF, 8'h00, 4'b1111,
                          8'h00, 8'h00, 8'h00, 8'h00, 16'hAAFF, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'hA55A, 4, 8'h05, 8'h12, 8'h82, 8'h00, 4'b1111,
                          8'h00, 8'h00, 8'h00, 8'hA5, 16'hAAFF, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'hA55A, 4, 8'h81, 8'h00, 8'h80, 8'h00, 4'b1111,
                          8'h00, 8'h5A, 8'h00, 8'h07, 16'hAAFF, 0, 7'd0, 7'd0));
        vecs.push_back(mk(16'h0000, 2, 8'h04, 8'h3C, 8'h00, 8'h00, 4'b0011,
                          8'h00, 8'h00, 8'h00, 8'h00, 16'h3CFF, 1, 7'd4, 7'd0));
        rw_final = 16'h3CFF;
`endif

        #20;
        vec_id = -1;
        chk("reset_rw_out0", 32'(rw0), 32'd0);
        chk("reset_rw_out3", 32'(rw3), 32'd0);
        chk("reset_miso", 32'({miso0, miso3}), 32'd0);
        chk("reset_miso_oe", 32'({oe0, oe3}), 32'd0);
        chk("reset_wr_stb", 32'({stb0, stb3}), 32'd0);
        chk("reset_wr_addr", 32'({wa0, wa3}), 32'd0);
        chk("reset_busy", 32'({busy0, busy3}), 32'd0);
        #20 rst = 1'b0;
        #(2*HALF);

        sel = 1'b0;
        run_mode(rw_final);
        sel = 1'b1;
        run_mode(rw_final);

        // Reset asserted mid-frame on the mode-3 DUT.
        vec_id = 200;
        set_ss(1'b0);
        #(HALF);
        xfer(8'h03, 8, 1'b0, r);
        xfer(8'h12, 4, 1'b0, r);
        rst = 1'b1;
        set_ss(1'b1);
        set_sck(1'b1);
        #20;
        chk("midrst_rw_out", 32'(rw3), 32'd0);
        chk("midrst_busy", 32'(busy3), 32'd0);
        chk("midrst_miso_oe", 32'(oe3), 32'd0);
        chk("midrst_other_rw_out", 32'(rw0), 32'd0);
        #20 rst = 1'b0;
        #(2*HALF);
        frame(2, {16'h0000, 8'h00, 8'h80}, rx);
        chk("post_rst_chip_id", 32'(rx[15:8]), 32'h07);
        chk("post_rst_rw_out", 32'(rw3), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- Parametrised SPI slave register bridge and successor to the fixed chip-ID/switch/LED SPI target in top.
- Exposes a configurable bank of read-only input bytes and read/write output bytes to an external SPI master, with selectable SPI mode.
- Sits between the board-level SPI pins (JC header) and fabric logic.
- Single system clock; SPI pins are oversampled, so there is no SCK clock domain.

Parameters:
- CHIP_ID, 8'h07, value returned when reading address 0.
- N_RO, 2, number of read-only input bytes; addresses 1..N_RO; range 1..63.
- N_RW, 2, number of read/write output bytes; addresses N_RO+1..N_RO+N_RW; range 1..64.
- SPI_MODE, 0, SPI mode 0..3, where CPOL=SPI_MODE[1] and CPHA=SPI_MODE[0].
- SYNC_STAGES, 2, synchroniser depth on sck/ss_n/mosi; range 2..3.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- sck  in  1  SPI clock from master (asynchronous).
- ss_n  in  1  slave select, active-low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  miso output enable; high while ss_n is low (synchronised).
- ro_in  in  8*N_RO  read-only bytes; byte k occupies bits [8k+7:8k] at address 1+k.
- rw_out  out  8*N_RW  R/W registers; byte k occupies bits [8k+7:8k] at address N_RO+1+k.
- wr_stb  out  1  one-cycle pulse on every committed register write.
- wr_addr  out  7  address of the last committed write; valid with wr_stb.
- busy  out  1  high while a frame is active (ss_n low).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: rw_out=0, miso=0, miso_oe=0, wr_stb=0, wr_addr=0, busy=0. The state machine resets to IDLE, and all shift registers and bit counters reset to 0.
- Synchronisation: sck, ss_n and mosi pass through SYNC_STAGES flops. Sample and shift edges are derived from the synchronised sck according to SPI_MODE. clk must be at least 8x the sck frequency.
- Mode 0 edges: sample on sck rise, shift on sck fall. Other modes follow the standard CPOL/CPHA rules.
- Byte format: MSB first. The command byte is bit7 R/W (1 = read) and bits[6:0] the address.
- State machine: IDLE -> CMD on ss_n fall. CMD -> DATA after the 8th sample of the command byte. DATA -> CMD after the 8th sample of the data byte (alternating command/data pairs within one frame). Any state -> IDLE on ss_n rise.
- Read:
  - At the end of the command byte, the addressed value is loaded into the TX shift register within 2 clk.
  - The MSB appears on miso before the first sample edge of the data byte, and the remaining bits shift out on shift edges.
  - The received data byte is discarded.
  - Read map: address 0 returns CHIP_ID, RO addresses return live ro_in captured at load time, RW addresses return rw_out, and any other address returns 8'h00.
- Write:
  - At the end of the data byte, if the address is an RW address, the register updates and wr_stb pulses within 2 clk; wr_addr holds that address.
  - Writes to address 0, RO addresses or unmapped addresses are ignored: no wr_stb.
  - During a write data byte, miso shifts out 8'h00.
- Command byte MISO: during the command byte, miso shifts out 8'h00.
- Abort: ss_n rising mid-byte discards the partial byte with no write and no wr_stb, and returns the state machine to IDLE. Bit counters clear at every ss_n fall.
- Reset mid-frame: all state returns to reset values immediately; the next frame starts from IDLE on the next ss_n fall.
- Simultaneous events: an ss_n rise in the same clk as the 8th sample completes that byte, so a write commits. ss_n is treated as deasserted only after its synchronised rise.
- sck edges while ss_n is high are ignored.

Optional Feature:
- Macro: SPI_BURST_AUTOINC_EN.
- Defined:
  - After a command byte, every following byte in the frame is a data byte; there is no return to CMD.
  - The address increments by 1 after each data byte and wraps from 127 to 0.
  - Reads preload the next address at each byte boundary.
  - Writes commit per byte, with one wr_stb per byte.
- Undefined: strict alternating command/data pairs as described above.

Test Plan:
- Reset, then ss_n low and send 0x80, 0x00, 0x80, 0x00 -> both second bytes return 0x07; rw_out stays 0.
- ro_in=16'h00FF; send 0x81,0x81 -> second byte returns 0xFF; send 0x82,0x82 -> returns 0x00.
- Send 0x03,0xFF then 0x04,0xAA -> rw_out=16'hAAFF; two wr_stb pulses with wr_addr 3 then 4; read back 0x83 -> 0xFF and 0x84 -> 0xAA.
- Write 0x00,0x55 (chip ID) and 0x7F,0x55 (unmapped) -> no wr_stb and rw_out unchanged; read 0xFF -> 0x00.
- Send 0x03 then 4 bits of 0x12, then raise ss_n -> no write and rw_out unchanged. Assert rst mid-frame -> rw_out=0 and busy=0.
- SPI_MODE=3 bench repeats scenarios 1 and 3 with identical results. With SPI_BURST_AUTOINC_EN, send 0x03,0x11,0x22 -> rw_out=16'h2211.
